// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: decodes op into datapath/memory controls and counts retired instructions.
// Latency: lw 5, sw/R-type/addi 4, beq/bne/j 3 cycles with zero-wait memory; outputs are combinational from state.
// Backpressure: FETCH, MEMRD and MEMWR stall while mem_ready is low; mem_ready is ignored in every other state.
module mips_mc_control #(
   parameter int CNT_W       = 32,
   parameter bit ENABLE_ADDI = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             pc_en,
   output logic [3:0]       state,
   output logic             retired,
   output logic             illegal,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   state_t     cur_state;
   state_t     nxt_state;
   logic [5:0] op_q;        // opcode captured in DECODE; later states never look at the live op
   logic       ir_write_raw;
   logic       pc_en_raw;

   // State register; reset abandons any in-flight instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur_state <= S_FETCH;
      else        cur_state <= nxt_state;
   end

   // Capture the opcode once, in DECODE, for MEMADR and BRANCH to use.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     op_q <= 6'd0;
      else if (cur_state == S_DECODE) op_q <= op;
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       retire_count <= '0;
      else if (retired) retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Next-state and per-state control outputs; everything defaults to 0.
   always_comb begin
      nxt_state    = S_FETCH;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      ir_write_raw = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      pc_source    = 2'b00;
      pc_en_raw    = 1'b0;
      retired      = 1'b0;
      illegal      = 1'b0;
      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_en_raw    = 1'b1;
               nxt_state    = S_DECODE;
            end else begin
               nxt_state = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               6'h00:        nxt_state = S_EXEC;
               6'h23, 6'h2B: nxt_state = S_MEMADR;
               6'h04, 6'h05: nxt_state = S_BRANCH;
               6'h02:        nxt_state = S_JUMP;
               6'h08: begin
                  if (ENABLE_ADDI) nxt_state = S_ADDIEX;
                  else             illegal   = 1'b1;
               end
               default:      illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (op_q == 6'h23) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read  = 1'b1;
            iord      = 1'b1;
            nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retired    = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retired   = mem_ready;
            nxt_state = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nxt_state = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retired   = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            pc_en_raw = ((op_q == 6'h04) & zero) | ((op_q == 6'h05) & ~zero);
            retired   = 1'b1;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_en_raw = 1'b1;
            retired   = 1'b1;
         end
         default: nxt_state = S_FETCH;
      endcase
   end

   // FETCH is the reset state and reacts to mem_ready, so its pulses are held off while reset is low.
   assign ir_write = ir_write_raw & reset;
   assign pc_en    = pc_en_raw & reset;
   assign state    = cur_state;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [5:0] op;
   logic       zero, mem_ready;
   logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       pc_en, retired, illegal;
   logic [3:0] state;
   logic [7:0] retire_count;

   logic [5:0] b_op;
   logic       b_zero, b_mem_ready;
   logic       b_mem_read, b_mem_write, b_iord, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a;
   logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
   logic       b_pc_en, b_retired, b_illegal;
   logic [3:0] b_state;
   logic [31:0] b_retire_count;

   mips_mc_control #(.CNT_W(8), .ENABLE_ADDI(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .pc_en(pc_en),
      .state(state), .retired(retired), .illegal(illegal), .retire_count(retire_count)
   );

   mips_mc_control #(.CNT_W(32), .ENABLE_ADDI(1'b0)) dut_noaddi (
      .clk(clk), .reset(reset), .op(b_op), .zero(b_zero), .mem_ready(b_mem_ready),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .iord(b_iord), .ir_write(b_ir_write),
      .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .alu_src_a(b_alu_src_a),
      .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .pc_source(b_pc_source), .pc_en(b_pc_en),
      .state(b_state), .retired(b_retired), .illegal(b_illegal), .retire_count(b_retire_count)
   );

   // control word: mem_read mem_write iord ir_write reg_dst mem_to_reg reg_write alu_src_a
   //               alu_src_b[2] alu_op[2] pc_source[2] pc_en retired illegal
   wire [16:0] ctl_act = {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
                          alu_src_a, alu_src_b, alu_op, pc_source, pc_en, retired, illegal};

   typedef struct {
      logic [5:0]  op;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] ctl;
   } vec_t;

   typedef struct {
      logic [3:0]  st;
      logic [16:0] ctl;
      logic [7:0]  cnt;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   ntests = 0;
   int   nfail  = 0;
   logic [7:0] exp_cnt = 8'd0;

   logic [16:0] C_FW, C_FR, C_DEC, C_DILL, C_MA, C_MR, C_MWB, C_MWW, C_MWD;
   logic [16:0] C_EX, C_AWB, C_AIWB, C_BT, C_BN, C_J;

   function automatic logic [16:0] mk(input logic mr, mw, io, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, aop, pcs,
                                      input logic pce, ret, ill);
      return {mr, mw, io, irw, rd, m2r, rw, asa, asb, aop, pcs, pce, ret, ill};
   endfunction

   function automatic vec_t v(input logic [5:0] o, input logic z, input logic r,
                              input logic [3:0] s, input logic [16:0] c);
      vec_t t;
      t.op = o; t.zero = z; t.rdy = r; t.st = s; t.ctl = c;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, check outputs at the falling edge.
   task automatic apply(input vec_t t, input string nm);
      exp_t e;
      op = t.op; zero = t.zero; mem_ready = t.rdy;
      e.st = t.st; e.ctl = t.ctl; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk({nm, ".state"}, {28'd0, state}, {28'd0, e.st});
      chk({nm, ".ctl"},   {15'd0, ctl_act}, {15'd0, e.ctl});
      chk({nm, ".count"}, {24'd0, retire_count}, {24'd0, e.cnt});
      if (e.ctl[1]) exp_cnt = exp_cnt + 8'd1;
      @(posedge clk); #1;
   endtask

   initial begin
      C_FW   = mk(1,0,0,0, 0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0,0);
      C_FR   = mk(1,0,0,1, 0,0,0,0, 2'b01, 2'b00, 2'b00, 1,0,0);
      C_DEC  = mk(0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0,0);
      C_DILL = mk(0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0,1);
      C_MA   = mk(0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0,0);
      C_MR   = mk(1,0,1,0, 0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0);
      C_MWB  = mk(0,0,0,0, 0,1,1,0, 2'b00, 2'b00, 2'b00, 0,1,0);
      C_MWW  = mk(0,1,1,0, 0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0);
      C_MWD  = mk(0,1,1,0, 0,0,0,0, 2'b00, 2'b00, 2'b00, 0,1,0);
      C_EX   = mk(0,0,0,0, 0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0,0);
      C_AWB  = mk(0,0,0,0, 1,0,1,0, 2'b00, 2'b00, 2'b00, 0,1,0);
      C_AIWB = mk(0,0,0,0, 0,0,1,0, 2'b00, 2'b00, 2'b00, 0,1,0);
      C_BT   = mk(0,0,0,0, 0,0,0,1, 2'b00, 2'b01, 2'b01, 1,1,0);
      C_BN   = mk(0,0,0,0, 0,0,0,1, 2'b00, 2'b01, 2'b01, 0,1,0);
      C_J    = mk(0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 2'b10, 1,1,0);

      // idle fetch, then lw (op changes after DECODE, MEMRD waits twice)
      tbl.push_back(v(6'h00,0,0, 4'd0, C_FW));
      tbl.push_back(v(6'h23,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h23,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h00,0,1, 4'd2, C_MA));
      tbl.push_back(v(6'h00,0,0, 4'd3, C_MR));
      tbl.push_back(v(6'h00,0,0, 4'd3, C_MR));
      tbl.push_back(v(6'h00,0,1, 4'd3, C_MR));
      tbl.push_back(v(6'h00,0,0, 4'd4, C_MWB));
      // sw with three wait cycles in MEMWR
      tbl.push_back(v(6'h2B,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h2B,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h23,0,0, 4'd2, C_MA));
      tbl.push_back(v(6'h00,0,0, 4'd5, C_MWW));
      tbl.push_back(v(6'h00,0,0, 4'd5, C_MWW));
      tbl.push_back(v(6'h00,0,0, 4'd5, C_MWW));
      tbl.push_back(v(6'h00,0,1, 4'd5, C_MWD));
      // R-type; mem_ready ignored in EXEC/ALUWB
      tbl.push_back(v(6'h00,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h00,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h00,0,1, 4'd6, C_EX));
      tbl.push_back(v(6'h00,0,1, 4'd7, C_AWB));
      // addi
      tbl.push_back(v(6'h08,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h08,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h08,0,0, 4'd10, C_MA));
      tbl.push_back(v(6'h08,0,0, 4'd11, C_AIWB));
      // beq zero=1 (live op changed to bne in BRANCH: captured op must win)
      tbl.push_back(v(6'h04,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h04,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h05,1,0, 4'd8, C_BT));
      // bne zero=1 -> not taken
      tbl.push_back(v(6'h05,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h05,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h05,1,0, 4'd8, C_BN));
      // bne zero=0 -> taken
      tbl.push_back(v(6'h05,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h05,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h05,0,0, 4'd8, C_BT));
      // beq zero=0 -> not taken
      tbl.push_back(v(6'h04,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h04,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h04,0,0, 4'd8, C_BN));
      // j
      tbl.push_back(v(6'h02,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h02,0,0, 4'd1, C_DEC));
      tbl.push_back(v(6'h02,0,0, 4'd9, C_J));
      // illegal opcode 0x3F
      tbl.push_back(v(6'h3F,0,1, 4'd0, C_FR));
      tbl.push_back(v(6'h3F,0,0, 4'd1, C_DILL));
      tbl.push_back(v(6'h3F,0,0, 4'd0, C_FW));

      // reset state, with mem_ready high to show no pulses leak out
      reset = 1'b0; op = 6'h00; zero = 1'b0; mem_ready = 1'b1;
      b_op = 6'h00; b_zero = 1'b0; b_mem_ready = 1'b0;
      #2;
      chk("rst.state", {28'd0, state}, 32'd0);
      chk("rst.count", {24'd0, retire_count}, 32'd0);
      chk("rst.pulses", {27'd0, retired, illegal, ir_write, reg_write, mem_write}, 32'd0);
      @(posedge clk); #1;
      chk("rst.ir_write_clk", {31'd0, ir_write}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // reset during a MEMRD wait abandons the lw
      apply(v(6'h23,0,1, 4'd0, C_FR), "abort.f");
      apply(v(6'h23,0,0, 4'd1, C_DEC), "abort.d");
      apply(v(6'h23,0,0, 4'd2, C_MA), "abort.a");
      op = 6'h23; zero = 1'b0; mem_ready = 1'b0;
      #2;
      chk("abort.inwait", {28'd0, state}, 32'd3);
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("abort.state", {28'd0, state}, 32'd0);
      chk("abort.pulses", {27'd0, retired, illegal, ir_write, reg_write, mem_write}, 32'd0);
      chk("abort.count", {24'd0, retire_count}, 32'd0);
      exp_cnt = 8'd0;
      @(posedge clk); #1;
      chk("abort.hold_state", {28'd0, state}, 32'd0);
      chk("abort.hold_ret", {31'd0, retired}, 32'd0);
      reset = 1'b1;
      apply(v(6'h02,0,1, 4'd0, C_FR), "resume.f");
      apply(v(6'h02,0,0, 4'd1, C_DEC), "resume.d");
      apply(v(6'h02,0,0, 4'd9, C_J), "resume.j");

      // 255 more j instructions: 256 since the reset, 8-bit count wraps to 0
      for (int k = 0; k < 255; k++) begin
         apply(v(6'h02,0,1, 4'd0, C_FR), "wrap.f");
         apply(v(6'h02,0,0, 4'd1, C_DEC), "wrap.d");
         apply(v(6'h02,0,0, 4'd9, C_J), "wrap.j");
      end
      apply(v(6'h00,0,0, 4'd0, C_FW), "wrap.idle");
      chk("wrap.zero", {24'd0, retire_count}, 32'd0);

      // addi is illegal when disabled
      b_op = 6'h08; b_mem_ready = 1'b1;
      @(negedge clk);
      chk("noaddi.fetch", {28'd0, b_state}, 32'd0);
      @(posedge clk); #1;
      b_mem_ready = 1'b0;
      @(negedge clk);
      chk("noaddi.decode", {28'd0, b_state}, 32'd1);
      chk("noaddi.illegal", {30'd0, b_illegal, b_retired}, 32'd2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("noaddi.back", {28'd0, b_state}, 32'd0);
      chk("noaddi.pulse1", {31'd0, b_illegal}, 32'd0);
      chk("noaddi.count", b_retire_count, 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter (legal 8..64).
REQ-002 Parameter ENABLE_ADDI, default 1; 1 decodes addi (op 0x08), 0 treats it as illegal.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op  input  6  opcode from the instruction register; sampled in DECODE only.
REQ-006 zero  input  1  ALU zero flag; used in BRANCH only.
REQ-007 mem_ready  input  1  memory handshake; high in the cycle the access completes.
REQ-008 mem_read, mem_write, iord, ir_write  output  1 each  memory and IR controls.
REQ-009 reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath selects and write enable.
REQ-010 alu_src_b, alu_op, pc_source  output  2 each  datapath selects.
REQ-011 pc_en  output  1  PC load enable, with branch resolution already applied.
REQ-012 state  output  4  current FSM state encoding, for debug.
REQ-013 retired  output  1  one-cycle pulse when an instruction completes.
REQ-014 illegal  output  1  one-cycle pulse when an undecodable opcode is seen.
REQ-015 retire_count  output  CNT_W  count of retired instructions.

Function
REQ-016 The state encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL return to FETCH on the next cycle.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
 - While mem_ready=0, hold in FETCH.
 - When mem_ready=1, pulse ir_write=1 and pc_en=1 in that cycle, then go to DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by op:
 - 0x00 -> EXEC
 - 0x23, 0x2B -> MEMADR
 - 0x04, 0x05 -> BRANCH
 - 0x02 -> JUMP
 - 0x08 -> ADDIEX (only when ENABLE_ADDI=1)
 - any other op -> FETCH with illegal=1
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEMRD if op=0x23, else MEMWR.
REQ-020 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-021 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retired=1; go to FETCH.
REQ-022 MEMWR: mem_write=1, iord=1; hold until mem_ready=1; in that cycle retired=1, then go to FETCH.
REQ-023 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go to ALUWB.
REQ-024 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retired=1; go to FETCH.
REQ-025 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDIWB.
REQ-026 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retired=1; go to FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, retired=1; go to FETCH.
 - pc_en = (op==0x04 & zero) | (op==0x05 & ~zero).
REQ-028 JUMP: pc_source=10, pc_en=1, retired=1; go to FETCH.
REQ-029 In every state, outputs not listed for that state SHALL be 0.
REQ-030 mem_read and mem_write SHALL never be high in the same cycle.
REQ-031 retire_count SHALL increment by 1 in each cycle retired=1 and wrap from 2^CNT_W-1 to 0.
REQ-032 illegal and retired SHALL never be high in the same cycle.
REQ-033 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.
REQ-034 Instruction latencies with zero-wait memory SHALL be:
 - lw: 5 cycles
 - sw, R-type, addi: 4 cycles
 - beq, bne, j: 3 cycles

Reset
REQ-035 While reset=0, the FSM SHALL be in FETCH, retire_count SHALL be 0, and retired, illegal, ir_write, reg_write and mem_write SHALL be 0, independent of clk.
REQ-036 A reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no retire pulse and no count change.
REQ-037 After reset is released, the first rising edge SHALL evaluate FETCH.

Verification
REQ-038 lw with mem_ready tied 1 -> states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 in cycle 5; retire_count=1.
REQ-039 sw with mem_ready low for 3 cycles in MEMWR -> mem_write held high for 4 cycles; retired pulses once, in the mem_ready cycle.
REQ-040 beq with zero=1 -> pc_en=1 in BRANCH; bne with zero=1 -> pc_en=0 in BRANCH; both retire.
REQ-041 op=0x3F, and separately op=0x08 with ENABLE_ADDI=0 -> illegal=1 for 1 cycle; DECODE->FETCH; retire_count unchanged.
REQ-042 CNT_W=8, 256 back-to-back j instructions -> retire_count wraps to 0.
REQ-043 reset=0 asserted mid-MEMRD wait -> state=0 and no retire pulse; after release, normal fetch resumes.
